// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the serial BCD adder.
// Optional digit checker in the top is enabled by BCD_SERIAL_CHECK_EN.
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_e;
endpackage

// File: rtl/bcd_serial_adder_if.sv
// Request/result bundle between a client and bcd_serial_adder.
// Invalid is only meaningful when BCD_SERIAL_CHECK_EN is defined.
interface bcd_serial_adder_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
);
  logic                        Start;
  logic [DIGIT_W*DIGITS-1:0]   Addend;
  logic [DIGIT_W*DIGITS-1:0]   Augend;
  logic                        Carry_in;
  logic [DIGIT_W*DIGITS-1:0]   Sum;
  logic                        Carry_out;
  logic                        Busy;
  logic                        Done;
  logic                        Invalid;

  modport master (
    output Start, Addend, Augend, Carry_in,
    input  Sum, Carry_out, Busy, Done, Invalid
  );

  modport slave (
    input  Start, Addend, Augend, Carry_in,
    output Sum, Carry_out, Busy, Done, Invalid
  );
endinterface

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD add with decimal correction.
// No configuration macros.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] z;

  always_comb begin
    z  = {1'b0, a} + {1'b0, b} + {4'b0, ci};
    co = z > {1'b0, BCD_MAX};
    s  = co ? (z[3:0] + BCD_CORR) : z[3:0];
  end
endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder, LSD first, one digit per clock.
// Define BCD_SERIAL_CHECK_EN to flag non-BCD operand digits.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic               Clk,
  input  logic               Reset_n,
  bcd_serial_adder_if.slave  bus
);
  localparam int W = DIGIT_W * DIGITS;

  state_e     state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] res_q, res_d;
  logic [W-1:0] sum_q, sum_d;
  logic [W-1:0] res_nxt;
  logic [4:0] cnt_q, cnt_d;
  logic       c_q, c_d;
  logic       co_q, co_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] dig_s;
  logic       dig_co;
  logic       last;
`ifdef BCD_SERIAL_CHECK_EN
  logic       err_q, err_d;
  logic       inv_q, inv_d;
`endif

  bcd_digit_add u_dig (
    .a  (a_q[3:0]),
    .b  (b_q[3:0]),
    .ci (c_q),
    .s  (dig_s),
    .co (dig_co)
  );

  // New digit enters at the top so digit 0 ends up at the bottom.
  assign res_nxt = (res_q >> DIGIT_W) | (W'(dig_s) << (W - DIGIT_W));
  assign last    = (cnt_q == 5'(DIGITS - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    co_d    = co_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef BCD_SERIAL_CHECK_EN
    err_d   = err_q;
    inv_d   = inv_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          a_d     = bus.Addend;
          b_d     = bus.Augend;
          c_d     = bus.Carry_in;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ADD;
`ifdef BCD_SERIAL_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      ADD: begin
        a_d   = a_q >> DIGIT_W;
        b_d   = b_q >> DIGIT_W;
        c_d   = dig_co;
        res_d = res_nxt;
        cnt_d = cnt_q + 5'd1;
`ifdef BCD_SERIAL_CHECK_EN
        err_d = err_q | (a_q[3:0] > BCD_MAX)
                      | (b_q[3:0] > BCD_MAX);
`endif
        if (last) begin
          sum_d   = res_nxt;
          co_d    = dig_co;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
`ifdef BCD_SERIAL_CHECK_EN
          inv_d   = err_d;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef BCD_SERIAL_CHECK_EN
      err_q   <= 1'b0;
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef BCD_SERIAL_CHECK_EN
      err_q   <= err_d;
      inv_q   <= inv_d;
`endif
    end
  end

  assign bus.Sum       = sum_q;
  assign bus.Carry_out = co_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
`ifdef BCD_SERIAL_CHECK_EN
  assign bus.Invalid   = inv_q;
`else
  assign bus.Invalid   = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder (DIGITS=4 plus a DIGITS=1 instance).
// Honours BCD_SERIAL_CHECK_EN for the expected Invalid flag.
module tb_bcd_serial_adder;
  localparam int D = 4;
  localparam int W = 4 * D;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;

  bcd_serial_adder_if #(.DIGITS(D)) bus ();
  bcd_serial_adder_if #(.DIGITS(1)) bus1 ();

  bcd_serial_adder #(.DIGITS(D)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  bcd_serial_adder #(.DIGITS(1)) dut1 (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus1)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         inv;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int busy_run = 0;
  logic [W-1:0] last_sum = '0;
  logic last_co = 1'b0;

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b,
                                 logic ci);
    exp_t e;
    bit bad = 0;
    longint va = 0, vb = 0, s, p = 1;
    int da, db, z, c;
    e.sum = '0;
    for (int i = 0; i < D; i++) begin
      da = int'(a[4*i +: 4]);
      db = int'(b[4*i +: 4]);
      if (da > 9 || db > 9) bad = 1;
      va += da * p;
      vb += db * p;
      p *= 10;
    end
    if (!bad) begin
      s = va + vb + longint'(ci);
      e.co = (s >= p);
      s = s % p;
      for (int i = 0; i < D; i++) begin
        e.sum[4*i +: 4] = 4'(s % 10);
        s = s / 10;
      end
    end else begin
      c = int'(ci);
      for (int i = 0; i < D; i++) begin
        z = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
        if (z > 9) begin
          e.sum[4*i +: 4] = 4'((z + 6) % 16);
          c = 1;
        end else begin
          e.sum[4*i +: 4] = 4'(z);
          c = 0;
        end
      end
      e.co = c[0];
    end
`ifdef BCD_SERIAL_CHECK_EN
    e.inv = bad;
`else
    e.inv = 1'b0;
`endif
    return e;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Monitor: pops the scoreboard on every Done.
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (bus.Busy && bus.Done) check("busy_with_done", 1, 0);
      if (bus.Busy) begin
        busy_run++;
        check("sum_hold", bus.Sum, last_sum);
        check("co_hold", bus.Carry_out, last_co);
      end
      if (bus.Done) begin
        check("busy_len", busy_run, D);
        busy_run = 0;
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("sum", bus.Sum, e.sum);
          check("carry_out", bus.Carry_out, e.co);
          check("invalid", bus.Invalid, e.inv);
          last_sum = e.sum;
          last_co = e.co;
        end
      end else if (!bus.Busy) begin
        busy_run = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((bus.Busy || bus.Done) && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 50) check("idle_timeout", 1, 0);
  endtask

  task automatic do_op(logic [W-1:0] a, logic [W-1:0] b, logic ci);
    wait_idle();
    bus.Start = 1'b1;
    bus.Addend = a;
    bus.Augend = b;
    bus.Carry_in = ci;
    q.push_back(model(a, b, ci));
    @(posedge Clk);
    #1;
    check("busy_rise", bus.Busy, 1);
    bus.Start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 50) check("drain_timeout", 1, 0);
    @(negedge Clk);
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.Addend = '0;
    bus.Augend = '0;
    bus.Carry_in = 1'b0;
    bus1.Start = 1'b0;
    bus1.Addend = '0;
    bus1.Augend = '0;
    bus1.Carry_in = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_sum", bus.Sum, 0);
    check("rst_co", bus.Carry_out, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_done", bus.Done, 0);
    check("rst_inv", bus.Invalid, 0);
    Reset_n = 1'b1;
    @(negedge Clk);

    do_op(16'h0999, 16'h0001, 1'b0);
    do_op(16'h9999, 16'h0001, 1'b0);
    do_op(16'h1234, 16'h4321, 1'b1);
    drain();

    // Start during ADD with new operands must be ignored.
    do_op(16'h2718, 16'h3141, 1'b0);
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Addend = 16'h8888;
    bus.Augend = 16'h7777;
    bus.Carry_in = 1'b1;
    @(negedge Clk);
    bus.Start = 1'b0;
    do_op(16'h0500, 16'h0500, 1'b0);
    drain();

    do_op(16'h00A0, 16'h0000, 1'b0);
    do_op(16'h0001, 16'h0001, 1'b0);
    do_op(16'hF0F0, 16'h0B0C, 1'b1);
    drain();

    for (int i = 0; i < 30; i++)
      do_op(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)));
    drain();

    // Reset in the second ADD cycle abandons the operation.
    do_op(16'h4444, 16'h5555, 1'b0);
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    q.delete();
    last_sum = '0;
    last_co = 1'b0;
    #1;
    check("mid_rst_sum", bus.Sum, 0);
    check("mid_rst_co", bus.Carry_out, 0);
    check("mid_rst_busy", bus.Busy, 0);
    check("mid_rst_done", bus.Done, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (10) @(negedge Clk);
    check("post_rst_busy", bus.Busy, 0);
    check("post_rst_sum", bus.Sum, 0);

    do_op(16'h9999, 16'h9999, 1'b1);
    drain();

    // Single-digit instance: 9 + 9 + 1.
    bus1.Start = 1'b1;
    bus1.Addend = 4'h9;
    bus1.Augend = 4'h9;
    bus1.Carry_in = 1'b1;
    @(posedge Clk);
    #1;
    bus1.Start = 1'b0;
    check("d1_busy", bus1.Busy, 1);
    check("d1_done_early", bus1.Done, 0);
    @(posedge Clk);
    #1;
    check("d1_done", bus1.Done, 1);
    check("d1_busy_off", bus1.Busy, 0);
    check("d1_sum", bus1.Sum, 4'h9);
    check("d1_co", bus1.Carry_out, 1);
    @(posedge Clk);
    #1;
    check("d1_done_pulse", bus1.Done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
